// File: rtl/load_store_unit.sv
// load_store_unit: multi-cycle byte/half/word load/store over a valid/ready bus.
// Define LSU_MISALIGN_TRAP_EN to trap misaligned accesses instead of forcing alignment.
module load_store_unit #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [2:0]  Funct3,
  input  logic [31:0] Addr,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  output logic        Stall,
  output logic        MisalignErr,
  output logic        BusErr,
  output logic        BusValid,
  input  logic        BusReady,
  output logic        BusWe,
  output logic [31:0] BusAddr,
  output logic [31:0] BusWData,
  output logic [3:0]  BusWStrb,
  input  logic [31:0] BusRData
);
  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
  state_t state;
  logic [2:0] f3;
  logic [1:0] lo;
  logic is_load;
  logic [7:0] cnt;
  logic req, half, word;
  logic [1:0] a_lo;
  logic [31:0] wdata_c, rdata_c;
  logic [3:0] strb_c;
  logic [7:0] rbyte;
  logic [15:0] rhalf;
  assign req = MemRead | MemWrite;
  assign half = Funct3[1:0] == 2'b01;
  assign word = Funct3[1];
  // Low address bits are always forced to the access size; with trapping enabled
  // misaligned requests never reach the bus, so the forcing is harmless there too.
  assign a_lo = word ? 2'b00 : half ? {Addr[1], 1'b0} : Addr[1:0];
  assign wdata_c = word ? WriteData : half ? {2{WriteData[15:0]}} : {4{WriteData[7:0]}};
  assign strb_c = !MemWrite ? 4'b0000 : word ? 4'b1111 : half ? (a_lo[1] ? 4'b1100 : 4'b0011) : 4'b0001 << a_lo;
  assign rbyte = BusRData[{lo, 3'b000} +: 8];
  assign rhalf = lo[1] ? BusRData[31:16] : BusRData[15:0];
  assign rdata_c = f3[1] ? BusRData : f3[0] ? {{16{~f3[2] & rhalf[15]}}, rhalf} : {{24{~f3[2] & rbyte[7]}}, rbyte};
  assign Stall = (state == ACCESS) | ((state == IDLE) & req);
  assign BusValid = state == ACCESS;
`ifdef LSU_MISALIGN_TRAP_EN
  logic mis, mis_err;
  assign mis = (half & Addr[0]) | (word & |Addr[1:0]);
  assign MisalignErr = mis_err;
`else
  assign MisalignErr = 1'b0;
`endif
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state <= IDLE;
      cnt <= '0;
      f3 <= '0;
      lo <= '0;
      is_load <= 1'b0;
      BusWe <= 1'b0;
      BusAddr <= '0;
      BusWData <= '0;
      BusWStrb <= '0;
      ReadData <= '0;
      BusErr <= 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
      mis_err <= 1'b0;
`endif
    end else begin
      BusErr <= 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
      mis_err <= 1'b0;
`endif
      case (state)
        IDLE: if (req) begin
          f3 <= Funct3;
          lo <= a_lo;
          is_load <= !MemWrite;
          BusWe <= MemWrite;
          BusAddr <= {Addr[31:2], 2'b00};
          BusWData <= wdata_c;
          BusWStrb <= strb_c;
          cnt <= '0;
`ifdef LSU_MISALIGN_TRAP_EN
          if (mis) begin
            state <= DONE;
            mis_err <= 1'b1;
            if (!MemWrite) ReadData <= '0;
          end else state <= ACCESS;
`else
          state <= ACCESS;
`endif
        end
        ACCESS: if (BusReady) begin
          state <= DONE;
          if (is_load) ReadData <= rdata_c;
        end else if (cnt == 8'(TIMEOUT_CYCLES - 1)) begin
          state <= DONE;
          BusErr <= 1'b1;
          if (is_load) ReadData <= '0;
        end else cnt <= cnt + 8'd1;
        default: state <= IDLE;
      endcase
    end
endmodule
